// File: rtl/riscv_pkg.sv
// Shared types for the riscv hart pipeline control: forward selects, shadow-stage metadata, memory FSM.
package riscv_pkg;

    localparam int unsigned RV_XLEN = 32;
    localparam int unsigned RV_REGN = 32;
    localparam int unsigned RV_REGA = $clog2(RV_REGN);

    typedef logic [RV_XLEN-1:0] xword_t;
    typedef logic [RV_REGA-1:0] regaddr_t;

    // Operand source select; encoding is what the EX operand muxes decode.
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_EX = 2'b01,
        FWD_MA = 2'b10,
        FWD_WB = 2'b11
    } fwd_sel_e;

    // Destination-register metadata of one in-flight instruction.
    typedef struct packed {
        logic     valid;
        regaddr_t rd;
        logic     wen;
        logic     load;
        logic     mem;
    } pipe_meta_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        FAULT = 2'b10
    } memfsm_e;

    // A source read depends on a stage when that stage writes the same non-x0 register.
    function automatic logic stage_hit(input logic use_src, input regaddr_t src, input pipe_meta_t m);
        return use_src & (src != '0) & m.valid & m.wen & (m.rd == src);
    endfunction

endpackage

// File: rtl/riscv_hazard_cmp.sv
// One source operand compared against the EX/MA/WB shadow stages.
module riscv_hazard_cmp
    import riscv_pkg::*;
(
    input  logic       i_use,
    input  regaddr_t   i_src,
    input  pipe_meta_t i_ex,
    input  pipe_meta_t i_ma,
    input  pipe_meta_t i_wb,
    output fwd_sel_e   o_fwd_sel_c,
    output logic       o_match_c,
    output logic       o_load_use_c
);

    logic w_ex_hit;
    logic w_ma_hit;
    logic w_wb_hit;
    logic w_unused;

    // Youngest producer wins: EX over MA over WB.
    always_comb begin
        w_ex_hit     = stage_hit(i_use, i_src, i_ex);
        w_ma_hit     = stage_hit(i_use, i_src, i_ma);
        w_wb_hit     = stage_hit(i_use, i_src, i_wb);
        o_fwd_sel_c  = FWD_RF;
        if (w_ex_hit) begin
            o_fwd_sel_c = FWD_EX;
        end else if (w_ma_hit) begin
            o_fwd_sel_c = FWD_MA;
        end else if (w_wb_hit) begin
            o_fwd_sel_c = FWD_WB;
        end
        o_match_c    = w_ex_hit | w_ma_hit | w_wb_hit;
        o_load_use_c = w_ex_hit & i_ex.load;
    end

    // Metadata fields this comparator has no use for.
    assign w_unused = &{1'b0, i_ex.mem, i_ma.load, i_ma.mem, i_wb.load, i_wb.mem};

endmodule

// File: rtl/riscv_pipe_ctrl.sv
// Pipeline control for the 5-stage hart: hazard stalls, bubbles, branch flush, forwarding, memory hold.
module riscv_pipe_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned REGN        = 32,
    parameter bit          FORWARD     = 1'b1,
    parameter int unsigned MEMWAIT_MAX = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [$clog2(REGN)-1:0] id_rs1,
    input  logic [$clog2(REGN)-1:0] id_rs2,
    input  logic                    id_use_rs1,
    input  logic                    id_use_rs2,
    input  logic [$clog2(REGN)-1:0] id_rd,
    input  logic                    id_wen,
    input  logic                    id_load,
    input  logic                    id_mem,
    input  logic                    branch_taken,
    input  logic                    mem_ready,
    output logic                    stall,
    output logic                    bubble_ex,
    output logic                    flush_id,
    output logic [1:0]              fwd_a,
    output logic [1:0]              fwd_b,
    output logic                    mem_wait,
    output logic                    mem_fault
);

    localparam int unsigned CNT_W = $clog2(MEMWAIT_MAX + 1);

    // Shadow metadata is sized by the package, so the hart must match it.
    if (XLEN != RV_XLEN || REGN != RV_REGN || MEMWAIT_MAX < 1) begin : g_param_check
        $fatal(1, "riscv_pipe_ctrl: unsupported XLEN/REGN/MEMWAIT_MAX");
    end

    pipe_meta_t       r_ex;
    pipe_meta_t       r_ma;
    pipe_meta_t       r_wb;
    pipe_meta_t       w_ma_eff;
    pipe_meta_t       w_ex_in;
    memfsm_e          r_state;
    memfsm_e          w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_out_en;
    logic             w_hold;
    logic             w_hazard;
    logic             w_flush;
    logic             w_stall;
    logic             w_bubble;
    fwd_sel_e         w_fwd_a;
    fwd_sel_e         w_fwd_b;
    fwd_sel_e         w_fwd_a_out;
    fwd_sel_e         w_fwd_b_out;
    logic             w_match_a;
    logic             w_match_b;
    logic             w_lu_a;
    logic             w_lu_b;

    // Outputs stay quiet for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_en <= 1'b0;
        end else begin
            r_out_en <= 1'b1;
        end
    end

    // A faulted access is dropped from MA so it neither holds nor forwards.
    always_comb begin
        w_ma_eff = r_ma;
        if (r_state == FAULT) begin
            w_ma_eff.valid = 1'b0;
        end
    end

    assign w_hold = r_out_en & w_ma_eff.valid & w_ma_eff.mem & ~mem_ready;

    riscv_hazard_cmp u_cmp_rs1 (
        .i_use        (id_use_rs1),
        .i_src        (RV_REGA'(id_rs1)),
        .i_ex         (r_ex),
        .i_ma         (w_ma_eff),
        .i_wb         (r_wb),
        .o_fwd_sel_c  (w_fwd_a),
        .o_match_c    (w_match_a),
        .o_load_use_c (w_lu_a)
    );

    riscv_hazard_cmp u_cmp_rs2 (
        .i_use        (id_use_rs2),
        .i_src        (RV_REGA'(id_rs2)),
        .i_ex         (r_ex),
        .i_ma         (w_ma_eff),
        .i_wb         (r_wb),
        .o_fwd_sel_c  (w_fwd_b),
        .o_match_c    (w_match_b),
        .o_load_use_c (w_lu_b)
    );

    // Hazard detection and the stall/bubble/flush combine; a taken branch overrides a hazard stall.
    always_comb begin
        w_hazard = 1'b0;
        if (FORWARD) begin
            w_hazard = w_lu_a | w_lu_b;
        end else begin
            w_hazard = w_match_a | w_match_b;
        end
        w_hazard = w_hazard & r_out_en;
        w_flush  = r_out_en & branch_taken & ~w_hold;
        w_stall  = w_hold | (w_hazard & ~w_flush);
        w_bubble = ~w_hold & (w_hazard | w_flush);
    end

    // Forward selects only matter when the instruction actually issues.
    always_comb begin
        w_fwd_a_out = FWD_RF;
        w_fwd_b_out = FWD_RF;
        if (FORWARD && r_out_en && !w_hazard) begin
            w_fwd_a_out = w_fwd_a;
            w_fwd_b_out = w_fwd_b;
        end
    end

    // Next EX entry: the ID instruction, or a bubble when it is killed or held back.
    always_comb begin
        w_ex_in.valid = id_valid;
        w_ex_in.rd    = RV_REGA'(id_rd);
        w_ex_in.wen   = id_wen;
        w_ex_in.load  = id_load;
        w_ex_in.mem   = id_mem;
        if (w_flush | w_hazard) begin
            w_ex_in.valid = 1'b0;
        end
    end

    // Shadow stages advance together unless memory holds the pipe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex <= '0;
            r_ma <= '0;
            r_wb <= '0;
        end else if (!w_hold) begin
            r_ex <= w_ex_in;
            r_ma <= r_ex;
            r_wb <= w_ma_eff;
        end
    end

    // Memory FSM state and wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Count held cycles; give up after MEMWAIT_MAX of them.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_hold) begin
                    if (MEMWAIT_MAX == 1) begin
                        w_state_nxt = FAULT;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                if (!w_hold) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if ((r_cnt + CNT_W'(1)) == CNT_W'(MEMWAIT_MAX)) begin
                    w_state_nxt = FAULT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            FAULT: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign stall     = w_stall;
    assign bubble_ex = w_bubble;
    assign flush_id  = w_flush;
    assign fwd_a     = w_fwd_a_out;
    assign fwd_b     = w_fwd_b_out;
    assign mem_wait  = w_hold;
    assign mem_fault = r_out_en & (r_state == FAULT);

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// Scoreboard bench for riscv_pipe_ctrl: one forwarding and one non-forwarding instance share stimulus.
module tb_riscv_pipe_ctrl;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       wen;
        logic       ld;
        logic       mem;
        logic       br;
        logic       rdy;
    } stim_t;

    // {stall, bubble_ex, flush_id, fwd_a, fwd_b, mem_wait, mem_fault}
    typedef logic [8:0] exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_use_rs1, id_use_rs2, id_wen, id_load, id_mem;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       branch_taken, mem_ready;

    logic       f_stall, f_bubble, f_flush, f_wait, f_fault;
    logic [1:0] f_fwd_a, f_fwd_b;
    logic       n_stall, n_bubble, n_flush, n_wait, n_fault;
    logic [1:0] n_fwd_a, n_fwd_b;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    riscv_pipe_ctrl #(.XLEN(32), .REGN(32), .FORWARD(1'b1), .MEMWAIT_MAX(15)) u_fwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wen(id_wen),
        .id_load(id_load), .id_mem(id_mem), .branch_taken(branch_taken), .mem_ready(mem_ready),
        .stall(f_stall), .bubble_ex(f_bubble), .flush_id(f_flush), .fwd_a(f_fwd_a),
        .fwd_b(f_fwd_b), .mem_wait(f_wait), .mem_fault(f_fault)
    );

    riscv_pipe_ctrl #(.XLEN(32), .REGN(32), .FORWARD(1'b0), .MEMWAIT_MAX(15)) u_nof (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wen(id_wen),
        .id_load(id_load), .id_mem(id_mem), .branch_taken(branch_taken), .mem_ready(mem_ready),
        .stall(n_stall), .bubble_ex(n_bubble), .flush_id(n_flush), .fwd_a(n_fwd_a),
        .fwd_b(n_fwd_b), .mem_wait(n_wait), .mem_fault(n_fault)
    );

    function automatic stim_t mk(logic v, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                 logic u1, logic u2, logic wen, logic ld, logic mem);
        stim_t s;
        s = '{v: v, rd: rd, rs1: rs1, rs2: rs2, u1: u1, u2: u2, wen: wen, ld: ld, mem: mem,
              br: 1'b0, rdy: 1'b1};
        return s;
    endfunction

    function automatic stim_t nop();
        return mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic stim_t add(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
        return mk(1'b1, rd, rs1, rs2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    endfunction

    function automatic stim_t lw(logic [4:0] rd, logic [4:0] rs1);
        return mk(1'b1, rd, rs1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    endfunction

    function automatic stim_t br(stim_t s);
        stim_t r = s;
        r.br = 1'b1;
        return r;
    endfunction

    function automatic stim_t slow(stim_t s);
        stim_t r = s;
        r.rdy = 1'b0;
        return r;
    endfunction

    function automatic exp_t E(logic s, logic b, logic f, logic [1:0] fa, logic [1:0] fb,
                               logic w, logic flt);
        return {s, b, f, fa, fb, w, flt};
    endfunction

    function automatic exp_t obs(bit nof);
        if (nof) return {n_stall, n_bubble, n_flush, n_fwd_a, n_fwd_b, n_wait, n_fault};
        return {f_stall, f_bubble, f_flush, f_fwd_a, f_fwd_b, f_wait, f_fault};
    endfunction

    task automatic apply(input stim_t s);
        id_valid     = s.v;
        id_rd        = s.rd;
        id_rs1       = s.rs1;
        id_rs2       = s.rs2;
        id_use_rs1   = s.u1;
        id_use_rs2   = s.u2;
        id_wen       = s.wen;
        id_load      = s.ld;
        id_mem       = s.mem;
        branch_taken = s.br;
        mem_ready    = s.rdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) begin
            apply(nop());
            next_cycle();
        end
    endtask

    task automatic test_reset();
        exp_t got, want;
        rst = 1'b0;
        apply(br(add(5'd5, 5'd1, 5'd2)));
        next_cycle();
        next_cycle();
        sb_q.push_back(E(0, 0, 0, 2'b00, 2'b00, 0, 0));
        #2;
        want = sb_q.pop_front();
        for (int d = 0; d < 2; d++) begin
            got = obs(d != 0);
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL reset_held dut%0d got=%b want=%b", d, got, want);
            end
        end
        apply(br(nop()));
        next_cycle();
        rst = 1'b1;
        sb_q.push_back(E(0, 0, 0, 2'b00, 2'b00, 0, 0));
        #2;
        want = sb_q.pop_front();
        for (int d = 0; d < 2; d++) begin
            got = obs(d != 0);
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL reset_release dut%0d got=%b want=%b", d, got, want);
            end
        end
        next_cycle();
        sb_q.push_back(E(0, 1, 1, 2'b00, 2'b00, 0, 0));
        #2;
        got  = obs(0);
        want = sb_q.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL reset_after_release got=%b want=%b", got, want);
        end
        apply(nop());
        next_cycle();
    endtask

    task automatic test_fwd_paths();
        stim_t st[7];
        exp_t  ex[7];
        exp_t  got, want;
        drain();
        st = '{add(5, 1, 2), add(6, 5, 1), add(7, 1, 2), nop(), add(8, 7, 6), add(8, 8, 0), add(1, 8, 8)};
        ex = '{E(0, 0, 0, 2'b00, 2'b00, 0, 0), E(0, 0, 0, 2'b01, 2'b00, 0, 0),
               E(0, 0, 0, 2'b00, 2'b00, 0, 0), E(0, 0, 0, 2'b00, 2'b00, 0, 0),
               E(0, 0, 0, 2'b10, 2'b11, 0, 0), E(0, 0, 0, 2'b01, 2'b00, 0, 0),
               E(0, 0, 0, 2'b01, 2'b01, 0, 0)};
        for (int i = 0; i < 7; i++) begin
            apply(st[i]);
            sb_q.push_back(ex[i]);
            #2;
            got  = obs(0);
            want = sb_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL fwd_paths cyc%0d got=%b want=%b", i, got, want);
            end
            next_cycle();
        end
    endtask

    task automatic test_load_use();
        stim_t st[3];
        exp_t  ex[3];
        exp_t  got, want;
        drain();
        st = '{lw(5, 1), add(6, 5, 5), add(6, 5, 5)};
        ex = '{E(0, 0, 0, 2'b00, 2'b00, 0, 0), E(1, 1, 0, 2'b00, 2'b00, 0, 0),
               E(0, 0, 0, 2'b10, 2'b10, 0, 0)};
        for (int i = 0; i < 3; i++) begin
            apply(st[i]);
            sb_q.push_back(ex[i]);
            #2;
            got  = obs(0);
            want = sb_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL load_use cyc%0d got=%b want=%b", i, got, want);
            end
            next_cycle();
        end
    endtask

    task automatic test_no_forward();
        stim_t st[6];
        exp_t  ex[6];
        exp_t  got, want;
        drain();
        st = '{add(5, 1, 2), add(6, 5, 1), add(6, 5, 1), add(6, 5, 1), add(6, 5, 1), add(7, 6, 0)};
        ex = '{E(0, 0, 0, 2'b00, 2'b00, 0, 0), E(1, 1, 0, 2'b00, 2'b00, 0, 0),
               E(1, 1, 0, 2'b00, 2'b00, 0, 0), E(1, 1, 0, 2'b00, 2'b00, 0, 0),
               E(0, 0, 0, 2'b00, 2'b00, 0, 0), E(1, 1, 0, 2'b00, 2'b00, 0, 0)};
        for (int i = 0; i < 6; i++) begin
            apply(st[i]);
            sb_q.push_back(ex[i]);
            #2;
            got  = obs(1);
            want = sb_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL no_forward cyc%0d got=%b want=%b", i, got, want);
            end
            next_cycle();
        end
    endtask

    task automatic test_x0();
        stim_t st[4];
        exp_t  got, want;
        drain();
        st = '{mk(1'b1, 5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), add(6, 0, 0), nop(), add(7, 0, 0)};
        for (int i = 0; i < 4; i++) begin
            apply(st[i]);
            sb_q.push_back(E(0, 0, 0, 2'b00, 2'b00, 0, 0));
            #2;
            want = sb_q.pop_front();
            for (int d = 0; d < 2; d++) begin
                got = obs(d != 0);
                n_cmp++;
                if (got !== want) begin
                    n_err++;
                    $display("FAIL x0 cyc%0d dut%0d got=%b want=%b", i, d, got, want);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_mem_wait();
        stim_t st[7];
        exp_t  ex[7];
        exp_t  got, want;
        drain();
        st = '{lw(5, 1), add(7, 1, 2), slow(add(8, 5, 7)), slow(add(8, 5, 7)), slow(add(8, 5, 7)),
               add(8, 5, 7), add(9, 5, 7)};
        ex = '{E(0, 0, 0, 2'b00, 2'b00, 0, 0), E(0, 0, 0, 2'b00, 2'b00, 0, 0),
               E(1, 0, 0, 2'b10, 2'b01, 1, 0), E(1, 0, 0, 2'b10, 2'b01, 1, 0),
               E(1, 0, 0, 2'b10, 2'b01, 1, 0), E(0, 0, 0, 2'b10, 2'b01, 0, 0),
               E(0, 0, 0, 2'b11, 2'b10, 0, 0)};
        for (int i = 0; i < 7; i++) begin
            apply(st[i]);
            sb_q.push_back(ex[i]);
            #2;
            got  = obs(0);
            want = sb_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL mem_wait cyc%0d got=%b want=%b", i, got, want);
            end
            next_cycle();
        end
    endtask

    task automatic test_mem_fault();
        stim_t s;
        exp_t  got, want;
        drain();
        for (int i = 0; i < 20; i++) begin
            if (i == 0) begin
                s = lw(5, 1);
                sb_q.push_back(E(0, 0, 0, 2'b00, 2'b00, 0, 0));
            end else if (i == 1) begin
                s = nop();
                sb_q.push_back(E(0, 0, 0, 2'b00, 2'b00, 0, 0));
            end else if (i <= 16) begin
                s = slow(add(6, 5, 0));
                sb_q.push_back(E(1, 0, 0, 2'b10, 2'b00, 1, 0));
            end else if (i == 17) begin
                s = slow(add(6, 5, 0));
                sb_q.push_back(E(0, 0, 0, 2'b00, 2'b00, 0, 1));
            end else if (i == 18) begin
                s = add(7, 5, 0);
                sb_q.push_back(E(0, 0, 0, 2'b00, 2'b00, 0, 0));
            end else begin
                s = nop();
                sb_q.push_back(E(0, 0, 0, 2'b00, 2'b00, 0, 0));
            end
            apply(s);
            #2;
            got  = obs(0);
            want = sb_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL mem_fault cyc%0d got=%b want=%b", i, got, want);
            end
            next_cycle();
        end
    endtask

    task automatic test_branch_flush();
        stim_t st[3];
        exp_t  ex[3];
        exp_t  got, want;
        drain();
        st = '{lw(5, 1), br(add(6, 5, 5)), nop()};
        ex = '{E(0, 0, 0, 2'b00, 2'b00, 0, 0), E(0, 1, 1, 2'b00, 2'b00, 0, 0),
               E(0, 0, 0, 2'b00, 2'b00, 0, 0)};
        for (int i = 0; i < 3; i++) begin
            apply(st[i]);
            sb_q.push_back(ex[i]);
            #2;
            got  = obs(0);
            want = sb_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL branch_flush cyc%0d got=%b want=%b", i, got, want);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_wait();
        stim_t st[4];
        exp_t  ex[4];
        exp_t  got, want;
        drain();
        st = '{lw(5, 1), nop(), slow(nop()), slow(nop())};
        ex = '{E(0, 0, 0, 2'b00, 2'b00, 0, 0), E(0, 0, 0, 2'b00, 2'b00, 0, 0),
               E(1, 0, 0, 2'b00, 2'b00, 1, 0), E(1, 0, 0, 2'b00, 2'b00, 1, 0)};
        for (int i = 0; i < 4; i++) begin
            apply(st[i]);
            sb_q.push_back(ex[i]);
            #2;
            got  = obs(0);
            want = sb_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL mid_wait_pre cyc%0d got=%b want=%b", i, got, want);
            end
            next_cycle();
        end
        apply(br(slow(nop())));
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 2) rst = 1'b1;
            if (i == 3) apply(slow(nop()));
            sb_q.push_back(E(0, 0, 0, 2'b00, 2'b00, 0, 0));
            #2;
            got  = obs(0);
            want = sb_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL mid_wait_reset cyc%0d got=%b want=%b", i, got, want);
            end
            next_cycle();
        end
        apply(nop());
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        apply(nop());
        rst = 1'b0;
        #1;
        test_reset();
        test_fwd_paths();
        test_load_use();
        test_no_forward();
        test_x0();
        test_mem_wait();
        test_mem_fault();
        test_branch_flush();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
